// File: rtl/data_memory_controller.sv
// Word-addressed backing RAM for the data cache: accepts one read or write
// request, waits a programmable number of cycles, then completes with a ready pulse.
module data_memory_controller #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 4
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] cache2mem_addr,
  input  logic [DATA_W-1:0] cache2mem_data,
  input  logic              cache2mem_MemWrite,
  input  logic              cache2mem_MemRead,
  output logic [DATA_W-1:0] mem2cache_data_in,
  output logic              mem2cache_ready,
  output logic              mem_busy
);

  // Handshake: a request level seen high at a rising edge while IDLE is
  // accepted; exactly LATENCY+1 cycles later mem2cache_ready is high for one
  // cycle, with read data valid in that same cycle. Inputs are ignored otherwise.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t              state;
  logic [7:0]          cnt;
  logic [DEPTH_W-1:0]  req_idx;
  logic [DATA_W-1:0]   req_data;
  logic                req_write;
  logic                access;
  logic                unused_addr_bits;

  logic [DATA_W-1:0]   mem [0:(1<<DEPTH_W)-1];

  // Byte offset and bits above the RAM range are don't-care (addresses alias).
  assign unused_addr_bits = ^{cache2mem_addr[ADDR_W-1:DEPTH_W+2], cache2mem_addr[1:0]};

  assign access   = (state == S_WAIT) && (cnt == 8'd0);
  assign mem_busy = (state != S_IDLE);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state             <= S_IDLE;
      cnt               <= 8'd0;
      req_idx           <= '0;
      req_data          <= '0;
      req_write         <= 1'b0;
      mem2cache_ready   <= 1'b0;
      mem2cache_data_in <= '0;
    end else begin
      mem2cache_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cache2mem_MemWrite || cache2mem_MemRead) begin
            req_idx   <= cache2mem_addr[DEPTH_W+1:2];
            req_data  <= cache2mem_data;
            req_write <= cache2mem_MemWrite;  // write wins when both are high
            cnt       <= CNT_INIT;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            state           <= S_RESP;
            mem2cache_ready <= 1'b1;
            if (!req_write) begin
              mem2cache_data_in <= mem[req_idx];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM is intentionally not reset; a reset mid-transaction leaves state in
  // IDLE, so a pending write can never reach this port.
  always_ff @(posedge iCLK) begin
    if (access && req_write) begin
      mem[req_idx] <= req_data;
    end
  end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Word-addressed backing RAM with a fixed-latency request/ready handshake. It sits directly downstream of the data cache controller. It services single-word line fills (read) and dirty-line write-backs (write) on the cache-to-memory port. It models main-memory access delay with a programmable wait count so the cache miss paths are exercised cycle-accurately.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width
- DEPTH_W, 10, log2 of RAM depth in words (2^DEPTH_W words)
- LATENCY, 4, wait cycles between accept and response; legal range 1..255
- iCLK  in  1  clock, all state updates on rising edge
- iRST_n  in  1  reset iRST_n, asynchronous, active-low; clock iCLK
- cache2mem_addr  in  ADDR_W  byte address of request
- cache2mem_data  in  DATA_W  write data
- cache2mem_MemWrite  in  1  write request level
- cache2mem_MemRead  in  1  read request level
- mem2cache_data_in  out  DATA_W  read result, registered
- mem2cache_ready  out  1  one-cycle completion pulse, registered
- mem_busy  out  1  high while a transaction is in flight (state != IDLE)

## Operation
- Word index = addr[DEPTH_W+1:2]. addr[1:0] is ignored (word aligned). Bits above DEPTH_W+1 are ignored, so addresses alias modulo 2^(DEPTH_W+2) bytes.
- The RAM array is not reset. Contents are undefined until written.
- FSM states:
  - IDLE: at an edge with MemRead or MemWrite high, latch addr, data and op; load cnt <= LATENCY-1; go to WAIT.
  - WAIT: if cnt==0, go to RESP and perform the access. Otherwise cnt <= cnt-1.
  - RESP: mem2cache_ready=1. Unconditionally go to IDLE at next edge.
- Access happens at the WAIT->RESP edge:
  - write: array[idx] <= latched data; mem2cache_data_in unchanged.
  - read: mem2cache_data_in <= array[idx].
- Both MemRead and MemWrite high at accept: write has priority, no read is performed.
- Inputs are ignored outside IDLE. Changes to addr, data or request during WAIT/RESP have no effect.
- A request still high in RESP is not re-accepted. It is accepted only if still high during the following IDLE cycle.
- mem2cache_data_in holds its last read value until the next read completes.
- cnt width is 8 bits.

## Timing
- Reset (async): state=IDLE, cnt=0, mem2cache_ready=0, mem2cache_data_in=0, mem_busy=0. The latched request is discarded.
- Reset mid-transaction: a pending write is never committed and no ready pulse is produced.
- Request high in IDLE cycle 0 produces:
  - WAIT in cycles 1..LATENCY
  - RESP and ready=1 in cycle LATENCY+1
  - IDLE in cycle LATENCY+2
- Read data is valid in the same cycle ready is high.
- mem_busy=1 in cycles 1..LATENCY+1.
- Minimum issue-to-issue spacing is LATENCY+2 cycles. This supports write-back immediately followed by fill: a request asserted in the cycle after ready is accepted.
- Ready is never high for two consecutive cycles.

## Test plan
(LATENCY=4, DEPTH_W=10)
- Reset: hold iRST_n=0, drive random inputs -> ready=0, data_out=0, busy=0. Release -> IDLE, with no ready until a request arrives.
- Write 0xDEADBEEF to 0x40 with MemWrite high from cycle 0 -> busy cycles 1..5, ready only in cycle 5, data_out stays 0.
- Read 0x40, MemRead cycle 0 -> ready cycle 5 with data_out=0xDEADBEEF; value held after MemRead drops.
- Aliasing and offset:
  - write 0x1 to 0x1000, then read 0x0 -> 0x1.
  - write 0x2 to 0x43, then read 0x40 -> 0x2.
- Write-back then fill:
  - write 0xA5 to 0x80 in cycle 0 -> ready cycle 5.
  - MemRead 0x84 from cycle 6 -> accepted, ready cycle 11.
  - MemWrite held through cycle 5 is not re-issued.
- Reset at cycle 3 of a write of 0x55 to 0x40 (old value 0xDEADBEEF) -> no ready pulse; a subsequent read returns 0xDEADBEEF.
- MemRead and MemWrite both high with data 0x77 at 0x8 -> array[2]=0x77, data_out unchanged, single ready pulse in cycle 5.
